// File: rtl/uart_reg_master.sv
// uart_reg_master: host command port to UART register-bus initiator, with an
// optional round-robin polling engine that drains received bytes.
//
// Optional feature macro: UART_AUTOPOLL_EN (polling engine present when defined).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata host command (valid/ready)
//   rsp_valid/ready/rdata           read response (valid/ready)
//   addr, we, re, write_data        register-bus strobes (one cycle each)
//   read_data                       register-bus read data (combinational)
//   poll_en                         per-channel poll enable
//   poll_valid/ready/chan/data      polled receive byte stream
module uart_reg_master #(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned POLL_DIV  = 1024,
    parameter int unsigned SR_RX_BIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              re,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic [3:0]        poll_en,
    output logic              poll_valid,
    input  logic              poll_ready,
    output logic [1:0]        poll_chan,
    output logic [7:0]        poll_data
);

    typedef enum logic [2:0] {IDLE, WR, RD, RSP, P_SR, P_RDR, P_OUT} state_t;

    state_t state;
    state_t state_nxt;
    logic   cmd_ready_nxt;

`ifdef UART_AUTOPOLL_EN
    localparam int unsigned CNT_W = $clog2(POLL_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             poll_due;
    logic             poll_due_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ch;
    logic [1:0]       sel_ch;
    logic [1:0]       cand;

    // First enabled channel at or after ptr; lowest offset wins.
    always_comb begin
        sel_ch = ptr;
        cand   = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (poll_en[cand]) sel_ch = cand;
        end
    end
`else
    logic unused_poll;
    assign unused_poll = ^{poll_en, poll_ready, 1'(SR_RX_BIT), 1'(POLL_DIV)};
    assign poll_valid  = 1'b0;
    assign poll_chan   = 2'b00;
    assign poll_data   = 8'h00;
`endif

    // Next state, plus next poll counter so cmd_ready can be registered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef UART_AUTOPOLL_EN
                if (poll_due) state_nxt = P_SR;
                else
`endif
                if (cmd_valid && cmd_ready) state_nxt = cmd_write ? WR : RD;
            end
            WR:  state_nxt = IDLE;
            RD:  state_nxt = RSP;
            RSP: if (rsp_ready) state_nxt = IDLE;
`ifdef UART_AUTOPOLL_EN
            P_SR:  state_nxt = read_data[SR_RX_BIT] ? P_RDR : IDLE;
            // First P_RDR cycle is the bus gap, second carries the strobe.
            P_RDR: if (re) state_nxt = P_OUT;
            P_OUT: if (poll_ready) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase

`ifdef UART_AUTOPOLL_EN
        cnt_nxt = cnt;
        if (state == IDLE && state_nxt == P_SR) cnt_nxt = CNT_W'(POLL_DIV - 1);
        else if (cnt != '0)                     cnt_nxt = cnt - CNT_W'(1);
        poll_due_nxt  = (cnt_nxt == '0) && (poll_en != 4'b0000);
        cmd_ready_nxt = (state_nxt == IDLE) && !poll_due_nxt;
`else
        cmd_ready_nxt = (state_nxt == IDLE);
`endif
    end

    // State register and registered outputs; strobes default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            addr       <= '0;
            we         <= 1'b0;
            re         <= 1'b0;
            write_data <= '0;
`ifdef UART_AUTOPOLL_EN
            cnt        <= CNT_W'(POLL_DIV - 1);
            poll_due   <= 1'b0;
            ptr        <= 2'd0;
            ch         <= 2'd0;
            poll_valid <= 1'b0;
            poll_chan  <= 2'd0;
            poll_data  <= 8'h00;
`endif
        end else begin
            state      <= state_nxt;
            cmd_ready  <= cmd_ready_nxt;
            addr       <= '0;
            we         <= 1'b0;
            re         <= 1'b0;
            write_data <= '0;
`ifdef UART_AUTOPOLL_EN
            cnt        <= cnt_nxt;
            poll_due   <= poll_due_nxt;
`endif
            case (state)
                IDLE: begin
`ifdef UART_AUTOPOLL_EN
                    if (poll_due) begin
                        ch   <= sel_ch;
                        re   <= 1'b1;
                        addr <= ADDR_W'({sel_ch, 2'b01});
                    end else
`endif
                    if (cmd_valid && cmd_ready) begin
                        addr <= cmd_addr;
                        if (cmd_write) begin
                            we         <= 1'b1;
                            write_data <= cmd_wdata;
                        end else begin
                            re <= 1'b1;
                        end
                    end
                end
                RD: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= read_data;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
`ifdef UART_AUTOPOLL_EN
                P_SR: begin
                    if (!read_data[SR_RX_BIT]) ptr <= ch + 2'd1;
                end
                P_RDR: begin
                    if (!re) begin
                        re   <= 1'b1;
                        addr <= ADDR_W'({ch, 2'b11});
                    end else begin
                        poll_valid <= 1'b1;
                        poll_chan  <= ch;
                        poll_data  <= read_data[7:0];
                    end
                end
                P_OUT: begin
                    if (poll_ready) begin
                        poll_valid <= 1'b0;
                        poll_chan  <= 2'd0;
                        poll_data  <= 8'h00;
                        ptr        <= ch + 2'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_master.sv
// Self-checking bench for uart_reg_master: table-driven command vectors plus
// hand-written reset and polling sequences.
module tb_uart_reg_master;

    localparam int unsigned ADDR_W   = 22;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned POLL_DIV = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic [3:0]        poll_en;
    logic              poll_valid;
    logic              poll_ready;
    logic [1:0]        poll_chan;
    logic [7:0]        poll_data;

    int total = 0;
    int bad   = 0;

    int n_double   = 0;
    int n_adjacent = 0;
    int n_strobes  = 0;
    int n_pvalid   = 0;
    logic prev_strobe = 1'b0;

    logic [31:0] regmem [16];

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] rd;
        int                hold;
    } vec_t;

    vec_t vecs [7];

    uart_reg_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_DIV(POLL_DIV), .SR_RX_BIT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .addr(addr), .we(we), .re(re), .write_data(write_data),
        .read_data(read_data),
        .poll_en(poll_en), .poll_valid(poll_valid), .poll_ready(poll_ready),
        .poll_chan(poll_chan), .poll_data(poll_data)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read of a small word array.
    assign read_data = (re && (addr < ADDR_W'(16))) ? regmem[addr[3:0]] : '0;

    // Bus-rule monitor.
    always @(negedge clk) begin
        if (we && re) n_double <= n_double + 1;
        if ((we || re) && prev_strobe) n_adjacent <= n_adjacent + 1;
        if (we || re) n_strobes <= n_strobes + 1;
        if (poll_valid) n_pvalid <= n_pvalid + 1;
        prev_strobe <= rst_n && (we || re);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int k;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.a;
        cmd_wdata = v.wd;
        k = 0;
        while (!cmd_ready && k < 20) begin
            step();
            k++;
        end
        check($sformatf("v%0d_ready_pre", idx), 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
        if (v.wr) begin
            check($sformatf("v%0d_we", idx), 64'(we), 64'd1);
            check($sformatf("v%0d_re", idx), 64'(re), 64'd0);
            check($sformatf("v%0d_addr", idx), 64'(addr), 64'(v.a));
            check($sformatf("v%0d_wdata", idx), 64'(write_data), 64'(v.wd));
            check($sformatf("v%0d_ready_lo", idx), 64'(cmd_ready), 64'd0);
            check($sformatf("v%0d_no_rsp", idx), 64'(rsp_valid), 64'd0);
            step();
            check($sformatf("v%0d_we_off", idx), 64'(we), 64'd0);
            check($sformatf("v%0d_addr_off", idx), 64'(addr), 64'd0);
            check($sformatf("v%0d_wdata_off", idx), 64'(write_data), 64'd0);
            check($sformatf("v%0d_ready_hi", idx), 64'(cmd_ready), 64'd1);
        end else begin
            check($sformatf("v%0d_re", idx), 64'(re), 64'd1);
            check($sformatf("v%0d_we", idx), 64'(we), 64'd0);
            check($sformatf("v%0d_addr", idx), 64'(addr), 64'(v.a));
            check($sformatf("v%0d_ready_lo", idx), 64'(cmd_ready), 64'd0);
            step();
            check($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'd1);
            check($sformatf("v%0d_rsp_rdata", idx), 64'(rsp_rdata), 64'(v.rd));
            check($sformatf("v%0d_re_off", idx), 64'(re), 64'd0);
            check($sformatf("v%0d_ready_rsp", idx), 64'(cmd_ready), 64'd0);
            for (int h = 0; h < v.hold; h++) begin
                step();
                check($sformatf("v%0d_hold%0d_valid", idx, h), 64'(rsp_valid), 64'd1);
                check($sformatf("v%0d_hold%0d_rdata", idx, h), 64'(rsp_rdata), 64'(v.rd));
                check($sformatf("v%0d_hold%0d_ready", idx, h), 64'(cmd_ready), 64'd0);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check($sformatf("v%0d_rsp_done", idx), 64'(rsp_valid), 64'd0);
            check($sformatf("v%0d_rdata_clr", idx), 64'(rsp_rdata), 64'd0);
            check($sformatf("v%0d_ready_back", idx), 64'(cmd_ready), 64'd1);
        end
    endtask

    // Counts edges after reset release until the first strobe.
    task automatic wait_strobe(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (!(re || we) && k < 64);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int k;
        int base;

        for (int i = 0; i < 16; i++) regmem[i] = 32'h0;
        regmem[1]  = 32'hDEADBEEF;
        regmem[3]  = 32'h0000005A;
        regmem[9]  = 32'h00000002;
        regmem[15] = 32'h12345678;

        vecs[0] = '{wr: 1'b1, a: 22'h000002, wd: 32'h00000041, rd: 32'h0,        hold: 0};
        vecs[1] = '{wr: 1'b0, a: 22'h000001, wd: 32'h0,        rd: 32'hDEADBEEF, hold: 5};
        vecs[2] = '{wr: 1'b1, a: 22'h3FFFFF, wd: 32'hFFFFFFFF, rd: 32'h0,        hold: 0};
        vecs[3] = '{wr: 1'b0, a: 22'h00000F, wd: 32'h0,        rd: 32'h12345678, hold: 0};
        vecs[4] = '{wr: 1'b1, a: 22'h000015, wd: 32'hA5A5A5A5, rd: 32'h0,        hold: 0};
        vecs[5] = '{wr: 1'b0, a: 22'h000003, wd: 32'h0,        rd: 32'h0000005A, hold: 1};
        vecs[6] = '{wr: 1'b0, a: 22'h000100, wd: 32'h0,        rd: 32'h0,        hold: 0};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        rsp_ready  = 1'b0;
        poll_en    = 4'b0000;
        poll_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_we", 64'(we), 64'd0);
        check("rst_re", 64'(re), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_poll_valid", 64'(poll_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while a response is pending.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 22'h000001;
        step();
        cmd_valid = 1'b0;
        check("rr_re", 64'(re), 64'd1);
        step();
        check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rr_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_drop_valid", 64'(rsp_valid), 64'd0);
        check("rr_drop_rdata", 64'(rsp_rdata), 64'd0);
        check("rr_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rr_after_valid", 64'(rsp_valid), 64'd0);
        check("rr_after_ready", 64'(cmd_ready), 64'd1);

`ifdef UART_AUTOPOLL_EN
        // Poll sequences: ch0 has data, ch2 does not.
        poll_en = 4'b0101;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(k);
        check("p1_latency", 64'(k), 64'd8);
        check("p1_sr_re", 64'(re), 64'd1);
        check("p1_sr_addr", 64'(addr), 64'h1);
        check("p1_sr_ready", 64'(cmd_ready), 64'd0);
        step();
        check("p1_gap_re", 64'(re), 64'd0);
        check("p1_gap_ready", 64'(cmd_ready), 64'd0);
        step();
        check("p1_rdr_re", 64'(re), 64'd1);
        check("p1_rdr_addr", 64'(addr), 64'h3);
        step();
        check("p1_out_valid", 64'(poll_valid), 64'd1);
        check("p1_out_chan", 64'(poll_chan), 64'd0);
        check("p1_out_data", 64'(poll_data), 64'h5A);
        check("p1_out_re", 64'(re), 64'd0);
        step();
        check("p1_hold_valid", 64'(poll_valid), 64'd1);
        check("p1_hold_data", 64'(poll_data), 64'h5A);
        poll_ready = 1'b1;
        step();
        poll_ready = 1'b0;
        check("p1_done_valid", 64'(poll_valid), 64'd0);
        check("p1_done_data", 64'(poll_data), 64'h0);
        check("p1_done_ready", 64'(cmd_ready), 64'd1);
        base = n_strobes;
        wait_strobe(k);
        check("p2_latency", 64'(k), 64'd3);
        check("p2_sr_addr", 64'(addr), 64'h9);
        step();
        check("p2_no_rdr", 64'(re), 64'd0);
        check("p2_ready", 64'(cmd_ready), 64'd1);
        repeat (5) step();
        check("p2_no_valid", 64'(n_pvalid), 64'd2);
        check("p2_one_strobe", 64'(n_strobes - base), 64'd1);
        check("pc_pre_ready", 64'(cmd_ready), 64'd1);

        // Command raised in the cycle the poll becomes due.
        step();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 22'h00002A;
        cmd_wdata = 32'h0000CAFE;
        check("pc_due_ready", 64'(cmd_ready), 64'd0);
        step();
        check("pc_sr_re", 64'(re), 64'd1);
        check("pc_sr_addr", 64'(addr), 64'h1);
        check("pc_sr_we", 64'(we), 64'd0);
        step();
        step();
        check("pc_rdr_addr", 64'(addr), 64'h3);
        step();
        check("pc_out_valid", 64'(poll_valid), 64'd1);
        check("pc_out_we", 64'(we), 64'd0);
        poll_ready = 1'b1;
        step();
        poll_ready = 1'b0;
        check("pc_idle_ready", 64'(cmd_ready), 64'd1);
        check("pc_idle_we", 64'(we), 64'd0);
        step();
        cmd_valid = 1'b0;
        check("pc_we", 64'(we), 64'd1);
        check("pc_addr", 64'(addr), 64'h2A);
        check("pc_wdata", 64'(write_data), 64'hCAFE);
        step();
        check("pc_ready_back", 64'(cmd_ready), 64'd1);

        // Reset while a polled byte is pending; pointer must restart at ch0.
        k = 0;
        while (!poll_valid && k < 40) begin
            step();
            k++;
        end
        check("po_valid", 64'(poll_valid), 64'd1);
        check("po_chan", 64'(poll_chan), 64'd0);
        poll_en = 4'b1001;
        rst_n = 1'b0;
        #1;
        check("po_drop_valid", 64'(poll_valid), 64'd0);
        check("po_drop_data", 64'(poll_data), 64'd0);
        check("po_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_strobe(k);
        check("po_latency", 64'(k), 64'd8);
        check("po_sr_addr", 64'(addr), 64'h1);
        step();
`else
        // Without the polling engine, enables must not produce bus traffic.
        poll_en    = 4'hF;
        poll_ready = 1'b1;
        base = n_strobes;
        repeat (5000) step();
        check("np_strobes", 64'(n_strobes - base), 64'd0);
        check("np_pvalid", 64'(n_pvalid), 64'd0);
        check("np_cmd_ready", 64'(cmd_ready), 64'd1);
        run_vec(7, vecs[1]);
`endif

        check("bus_double", 64'(n_double), 64'd0);
        check("bus_gap", 64'(n_adjacent), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
